// File: rtl/serial_byte_deserializer.sv
// serial_byte_deserializer
// Assembles a framed serial bit stream (sfirst marks bit 1 of a word) into
// WIDTH-bit words and offers them downstream through a one-entry holding
// register with a valid/ready handshake. An early sfirst aborts the partial
// word and pulses framerr. A word that completes while the holding register
// is still occupied and not being consumed is dropped, which sets the
// sticky ovf flag.
module serial_byte_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sdata,
   input  logic             svalid,
   input  logic             sfirst,
   output logic [WIDTH-1:0] outbyte,
   output logic             outvalid,
   input  logic             outready,
   output logic             framerr,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_outbyte;
   logic             r_outvalid;
   logic             r_framerr;
   logic             r_ovf;

   state_t           w_state;
   logic [CW-1:0]    w_cnt;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_outbyte;
   logic             w_outvalid;
   logic             w_framerr;
   logic             w_ovf;
   logic             w_complete;
   logic [WIDTH-1:0] w_bit_ext;
   logic [WIDTH-1:0] w_shift_in;
   logic [WIDTH-1:0] w_fresh;

   // Candidate shift-register values: append sdata to the partial word, or start a new word with sdata alone
   always_comb begin
      w_bit_ext  = {{(WIDTH-1){1'b0}}, sdata};
      w_shift_in = r_shift;
      w_fresh    = {WIDTH{1'b0}};
      if (MSB_FIRST) begin
         w_shift_in = (r_shift << 1) | w_bit_ext;
         w_fresh    = w_bit_ext;
      end else begin
         w_shift_in = (r_shift >> 1) | (w_bit_ext << (WIDTH - 1));
         w_fresh    = w_bit_ext << (WIDTH - 1);
      end
   end

   // Framing FSM next-state plus holding-register / flag update
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_shift    = r_shift;
      w_outbyte  = r_outbyte;
      w_outvalid = r_outvalid;
      w_ovf      = r_ovf;
      w_framerr  = 1'b0;
      w_complete = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Bits without sfirst are ignored until a frame starts
            if (svalid && sfirst) begin
               w_shift = w_fresh;
               w_cnt   = CW'(1);
               w_state = S_SHIFT;
            end else begin
               w_state = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (svalid && sfirst) begin
               // Early start marker: drop partial word, this bit becomes bit 1.
               // Takes priority over completion (matters for WIDTH = 2).
               w_framerr = 1'b1;
               w_shift   = w_fresh;
               w_cnt     = CW'(1);
            end else if (svalid) begin
               w_shift = w_shift_in;
               if (r_cnt == LAST_CNT) begin
                  w_complete = 1'b1;
                  w_cnt      = {CW{1'b0}};
                  w_state    = S_IDLE;
               end else begin
                  w_cnt = r_cnt + CW'(1);
               end
            end else begin
               w_state = S_SHIFT;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = {CW{1'b0}};
            w_shift = {WIDTH{1'b0}};
         end
      endcase

      if (w_complete) begin
         // A consume in the same cycle frees the slot, so load without a bubble
         if (!r_outvalid || outready) begin
            w_outbyte  = w_shift_in;
            w_outvalid = 1'b1;
         end else begin
            w_ovf = 1'b1;
         end
      end else if (r_outvalid && outready) begin
         w_outvalid = 1'b0;
      end else begin
         w_outvalid = r_outvalid;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= {CW{1'b0}};
         r_shift    <= {WIDTH{1'b0}};
         r_outbyte  <= {WIDTH{1'b0}};
         r_outvalid <= 1'b0;
         r_framerr  <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_shift    <= w_shift;
         r_outbyte  <= w_outbyte;
         r_outvalid <= w_outvalid;
         r_framerr  <= w_framerr;
         r_ovf      <= w_ovf;
      end
   end

   assign outbyte  = r_outbyte;
   assign outvalid = r_outvalid;
   assign framerr  = r_framerr;
   assign ovf      = r_ovf;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Testbench for serial_byte_deserializer: an MSB-first and an LSB-first
// instance share one stimulus stream; a queue-based reference model of the
// framing/handshake rules predicts every output cycle by cycle, and directed
// constants pin down the documented scenarios.
module tb_serial_byte_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sdata;
   logic         svalid;
   logic         sfirst;
   logic         outready;
   logic [W-1:0] ob1, ob0;
   logic         ov1, ov0, fe1, fe0, ovf1, ovf0;

   int n_tests = 0;
   int n_fail  = 0;
   int vhigh   = 0;

   // reference model state
   bit           mq[$];
   logic [W-1:0] m_w1, m_w0;
   logic         m_valid, m_ferr, m_ovf;

   serial_byte_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .sdata(sdata), .svalid(svalid), .sfirst(sfirst),
      .outbyte(ob1), .outvalid(ov1), .outready(outready), .framerr(fe1), .ovf(ovf1));

   serial_byte_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .sdata(sdata), .svalid(svalid), .sfirst(sfirst),
      .outbyte(ob0), .outvalid(ov0), .outready(outready), .framerr(fe0), .ovf(ovf0));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply the specification rules for one rising edge, using the inputs present at that edge
   task automatic model_edge();
      logic         done;
      logic [W-1:0] nw1, nw0;
      done = 1'b0;
      nw1  = '0;
      nw0  = '0;
      if (!rst_n) begin
         mq.delete();
         m_w1 = '0; m_w0 = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      end else begin
         m_ferr = 1'b0;
         if (svalid) begin
            if (sfirst) begin
               if (mq.size() != 0) m_ferr = 1'b1;
               mq.delete();
               mq.push_back(sdata);
            end else if (mq.size() != 0) begin
               mq.push_back(sdata);
               if (mq.size() == W) begin
                  done = 1'b1;
                  for (int i = 0; i < W; i++) begin
                     if (mq[i]) begin
                        nw1[W-1-i] = 1'b1;
                        nw0[i]     = 1'b1;
                     end
                  end
                  mq.delete();
               end
            end
         end
         if (done) begin
            if (!m_valid || outready) begin
               m_w1 = nw1; m_w0 = nw0; m_valid = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end else if (m_valid && outready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // One clock: advance model at the edge, then compare both DUTs just after it
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (ov1) vhigh++;
      chk("byte_msb", ob1, m_w1);
      chk("byte_lsb", ob0, m_w0);
      chk("valid_msb", ov1, m_valid);
      chk("valid_lsb", ov0, m_valid);
      chk("framerr_msb", fe1, m_ferr);
      chk("framerr_lsb", fe0, m_ferr);
      chk("ovf_msb", ovf1, m_ovf);
      chk("ovf_lsb", ovf0, m_ovf);
   endtask

   task automatic send_bit(input logic b, input logic first, input int maxgap);
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
         svalid = 1'b0; sfirst = 1'b0; sdata = 1'($urandom);
         step();
      end
      sdata = b; sfirst = first; svalid = 1'b1;
      step();
      svalid = 1'b0; sfirst = 1'b0;
   endtask

   // Transmit a word in the order w[7] first ... w[0] last
   task automatic send_word(input logic [W-1:0] w, input int maxgap);
      for (int i = 0; i < W; i++) send_bit(w[W-1-i], (i == 0), maxgap);
   endtask

   initial begin
      logic [W-1:0] rw;
      logic [W-1:0] w7e;
      rst_n = 1'b0; sdata = 1'b0; svalid = 1'b0; sfirst = 1'b0; outready = 1'b0;
      m_w1 = '0; m_w0 = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      #2;
      step();
      step();
      chk("rst_byte", ob1, 8'h00);
      chk("rst_valid", ov1, 1'b0);
      chk("rst_framerr", fe1, 1'b0);
      chk("rst_ovf", ovf1, 1'b0);
      rst_n = 1'b1;

      // basic word, both bit orders
      outready = 1'b1;
      send_word(8'hB2, 0);
      chk("t1_msb_byte", ob1, 8'hB2);
      chk("t1_lsb_byte", ob0, 8'h4D);
      chk("t1_valid", ov1, 1'b1);
      step();
      chk("t1_valid_one_cycle", ov1, 1'b0);

      // abort after 3 bits, then full 8'hFF
      vhigh = 0;
      send_bit(1'b1, 1'b1, 0);
      send_bit(1'b0, 1'b0, 0);
      send_bit(1'b1, 1'b0, 0);
      send_bit(1'b1, 1'b1, 0);
      chk("t2_framerr_pulse", fe1, 1'b1);
      send_bit(1'b1, 1'b0, 0);
      chk("t2_framerr_drop", fe1, 1'b0);
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 0);
      chk("t2_byte", ob1, 8'hFF);
      chk("t2_valid", ov1, 1'b1);
      step();
      chk("t2_valid_once", vhigh, 1);

      // backpressure and overflow
      outready = 1'b0;
      send_word(8'h0F, 0);
      chk("t3_first_byte", ob1, 8'h0F);
      chk("t3_ovf_clear", ovf1, 1'b0);
      send_word(8'hF0, 0);
      chk("t3_byte_held", ob1, 8'h0F);
      chk("t3_valid_held", ov1, 1'b1);
      chk("t3_ovf_set", ovf1, 1'b1);
      outready = 1'b1;
      step();
      chk("t3_valid_drop", ov1, 1'b0);
      chk("t3_ovf_sticky", ovf1, 1'b1);

      // back-to-back with ready only on the second completion
      rst_n = 1'b0; step(); rst_n = 1'b1;
      outready = 1'b0;
      send_word(8'h81, 0);
      w7e = 8'h7E;
      for (int i = 0; i < W - 1; i++) send_bit(w7e[W-1-i], (i == 0), 0);
      chk("t4_hold_81", ob1, 8'h81);
      outready = 1'b1;
      send_bit(w7e[0], 1'b0, 0);
      outready = 1'b0;
      chk("t4_byte", ob1, 8'h7E);
      chk("t4_valid", ov1, 1'b1);
      chk("t4_ovf", ovf1, 1'b0);

      // gapped bits, reset mid-word with a held word, then fresh word
      rw = 8'($urandom);
      for (int i = 0; i < 5; i++) send_bit(rw[W-1-i], (i == 0), 3);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("t5_rst_byte", ob1, 8'h00);
      chk("t5_rst_byte_lsb", ob0, 8'h00);
      chk("t5_rst_valid", ov1, 1'b0);
      chk("t5_rst_ovf", ovf1, 1'b0);
      outready = 1'b1;
      send_word(8'h03, 3);
      chk("t5_byte", ob1, 8'h03);
      chk("t5_valid", ov1, 1'b1);

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         svalid   = ($urandom_range(9, 0) < 7);
         sfirst   = svalid && ($urandom_range(9, 0) == 0);
         sdata    = 1'($urandom);
         outready = 1'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_byte_deserializer.md
Name: serial_byte_deserializer

Overview:
- Upstream stage of the bit counter.
- Collects a framed serial bit stream into WIDTH-bit words.
- Presents each word on outbyte, which drives the bit counter's inbyte, using a valid/ready handshake with a one-entry holding register.
- Flags framing errors and overflow so downstream popcount results can be qualified.

Parameters:
- WIDTH, 8, number of bits per assembled word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in outbyte[WIDTH-1]; 0 = first bit lands in outbyte[0].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- sdata  input  1  serial data bit.
- svalid  input  1  sdata is valid this cycle.
- sfirst  input  1  qualified by svalid; marks the first bit of a word.
- outbyte  output  WIDTH  assembled word (registered); feeds the bit counter's inbyte.
- outvalid  output  1  outbyte holds an unconsumed word.
- outready  input  1  consumer accepts the word when outvalid && outready.
- framerr  output  1  one-cycle pulse: the current word was aborted by an early sfirst.
- ovf  output  1  sticky: a completed word was dropped because the holding register was full; cleared only by reset.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state = IDLE, bit count = 0, shift register = 0.
  - outbyte = 0, outvalid = 0, framerr = 0, ovf = 0.
  - Reset mid-word discards the partial word and any held word.
- Bit counter is $clog2(WIDTH+1) bits wide and counts accepted bits.
- State machine:
  - IDLE, svalid && sfirst: shift in sdata, count = 1, go to SHIFT.
  - IDLE, svalid && !sfirst: bit ignored, no flag, stay in IDLE.
  - IDLE, !svalid: hold.
  - SHIFT, svalid && !sfirst: shift in sdata, count++.
  - SHIFT, bit accepted and count reaches WIDTH: word complete, attempt a load into the holding register, count = 0, go to IDLE.
  - SHIFT, svalid && sfirst (count < WIDTH): abort the partial word, framerr = 1 for exactly one cycle, restart with this bit as bit 1 (count = 1), stay in SHIFT.
  - SHIFT, !svalid: hold; there is no timeout.
  - WIDTH = 2, sfirst on the second bit: treated as an abort and restart, not a completion.
- Bit ordering:
  - MSB_FIRST = 1: the shift register shifts left; the first bit ends in bit WIDTH-1.
  - MSB_FIRST = 0: the first bit ends in bit 0.
- Latency:
  - The final bit is accepted on edge N.
  - outbyte is updated and outvalid = 1 immediately after edge N; visible in cycle N+1.
  - A full WIDTH-bit word with svalid held high takes WIDTH cycles, then appears on the next cycle.
- Handshake:
  - outbyte and outvalid stay stable while outvalid && !outready.
  - outvalid && outready at an edge with no completion: outvalid -> 0 and outbyte holds its last value.
- Completion cases (checked at the edge of completion):
  - Register empty, or outvalid && outready this same cycle: load the new word; outvalid = 1 (back-to-back, no bubble).
  - Register full and not consumed: drop the new word, set ovf = 1, leave outbyte/outvalid unchanged.
- outready is ignored while outvalid = 0.
- framerr and a completion never occur in the same cycle.
- framerr does not affect outvalid or the held word.

Test Plan:
- Reset, then stream 1,0,1,1,0,0,1,0 with sfirst on bit 1, svalid continuous, outready = 1 (MSB_FIRST = 1) -> outbyte = 8'hB2, outvalid high exactly 1 cycle, 9 cycles after the first bit.
- Same stream with MSB_FIRST = 0 -> outbyte = 8'h4D.
- Abort: send 3 bits, then sfirst with a new 8-bit word 8'hFF -> framerr pulses 1 cycle at the 4th bit; outbyte = 8'hFF; outvalid rises once only.
- Backpressure: outready = 0, send word 8'h0F then 8'hF0 -> outbyte stays 8'h0F, ovf = 1 after the second completion. Raise outready -> outvalid drops next cycle; ovf stays 1.
- Back-to-back: two consecutive words 8'h81, 8'h7E, with outready pulsed exactly on the second completion cycle -> 8'h7E loads with no gap, ovf = 0.
- Gapped svalid (random idle cycles) plus rst_n = 0 after 5 bits -> all outputs 0 the next cycle; a following full word 8'h03 is assembled correctly from count 0.
